datamemory_bytelane: RTL and testbench
======================================

// Module: datamemory_bytelane
// PURPOSE
//  Byte-addressed, parametrised-depth data memory for the CPU MEM stage. Supports byte, half
//  and word loads/stores with little-endian lane placement and load sign/zero extension.
//  Reads are registered with one cycle of latency. Misaligned accesses are flagged.
//  Reset optionally runs a hardware clear sweep before accepting accesses.
// PARAMETERS
//  DEPTH_WORDS     1024  number of 32-bit words; power of two, >= 4
//  CLEAR_ON_RESET  1     1: reset zeroes every word, one word per cycle; 0: contents are kept
// PORTS
//  clk         in   1   clock; all state updates on its rising edge
//  reset       in   1   synchronous, active-high
//  memRE       in   1   read request
//  memWE       in   1   write request
//  size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  signExt     in   1   1: sign-extend byte/half loads; 0: zero-extend
//  Addr        in   32  byte address
//  DataIn      in   32  store data; byte/half data is taken from the low bits
//  DataOut     out  32  registered load result
//  dataValid   out  1   one-cycle pulse: DataOut holds the result of the read accepted last cycle
//  misaligned  out  1   one-cycle pulse: the access accepted last cycle was misaligned or illegal
//  ready       out  1   high when accesses are accepted
// BEHAVIOUR
//  - Word index = Addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
//  - Lane = Addr[1:0]. A byte at lane k occupies bits 8k+7:8k. A half at lane 0 uses bits 15:0; at lane 2, bits 31:16.
//  - Misaligned: half with Addr[0]=1, word with Addr[1:0]!=0, or size=11.
//    On a misaligned access the write is suppressed, DataOut holds its value, dataValid=0, misaligned=1 next cycle.
//  - Write: memWE & ready & aligned updates only the addressed byte lanes at the clock edge.
//  - Read: memRE & ready & aligned. The next cycle gives DataOut = extracted and extended value, dataValid=1.
//    DataOut holds between reads.
//  - memRE & memWE in the same cycle: write-first. The read returns the merged post-write word, extracted per size.
//  - A write followed by a read of the same word in the next cycle returns the new data (no stale read).
//  - FSM states are CLEAR and RUN.
//    - reset=1: counter <= 0; DataOut, dataValid, misaligned <= 0; ready <= 0; state <= CLEAR if CLEAR_ON_RESET else RUN.
//    - CLEAR: writes 0 to word[counter] and increments the counter each cycle.
//      After the write of word DEPTH_WORDS-1, state becomes RUN and ready=1 on the following cycle.
//      A full sweep takes DEPTH_WORDS cycles after reset is released.
//    - RUN: ready=1. Accesses are processed as above.
//  - Requests while ready=0 are ignored: no write, no dataValid, no misaligned.
//  - Reset asserted mid-sweep or mid-access aborts it. The sweep restarts from word 0, and an in-flight dataValid is cancelled.
//  - With CLEAR_ON_RESET=0, power-up contents are undefined and ready=1 in the first cycle after reset deasserts.
// STRUCTURE
//  - Shared package/header holds SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_ILLEGAL=2'b11 and the
//    FSM state encodings ST_CLEAR and ST_RUN. The CPU control decoder uses the same size constants.
//  - One combinational sub-module, mem_load_align(word, lane, size, signExt -> value), does lane extraction and extension.
//  - Byte-enable generation and the write merge stay inline in this module.
//  - Storage is one reg array [0:DEPTH_WORDS-1] of 32 bits.
// TESTING
//  1 Clear sweep: DEPTH_WORDS=16, CLEAR_ON_RESET=1, pulse reset -> ready=0 for 16 cycles, then 1;
//    word read at Addr=0x3C -> DataOut=0x00000000, dataValid pulse.
//  2 Lanes: sw 0x11223344 @0x8; sb 0xAA @0xA -> lw @0x8 = 0x11AA3344;
//    lb signExt=1 @0xA = 0xFFFFFFAA; lbu @0xA = 0x000000AA.
//  3 Halves: sh 0x8001 @0x6 -> lh @0x6 = 0xFFFF8001; lhu @0x6 = 0x00008001; lw @0x4 low half unchanged.
//  4 Misaligned: lw @0x5 -> misaligned=1, dataValid=0, DataOut unchanged;
//    sh 0xBEEF @0x3 -> word 0 unchanged on readback; size=11 -> misaligned=1.
//  5 Write-first and back-to-back: memRE=memWE=1, sw 0xCAFEF00D @0x10 -> next-cycle DataOut=0xCAFEF00D;
//    sw 0x1 @0x14 then lw @0x14 on the next cycle -> 0x00000001.
//  6 Reset mid-sweep and wrap: assert reset at sweep cycle 5 -> ready low for a full 16 cycles after release;
//    sw 0x5A5A5A5A @0x40 -> lw @0x0 returns 0x5A5A5A5A; requests during ready=0 produce no pulses.

Source files
------------

// File: rtl/datamemory_bytelane_pkg.sv
// Shared definitions for the byte-lane data memory: access-size codes, FSM states
// and the alignment rule used by both the memory and the CPU control decoder.
package datamemory_bytelane_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } memState_t;

  // Halves must sit on an even byte, words on a 4-byte boundary; the illegal size never passes.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE:    bad = 1'b0;
      SIZE_HALF:    bad = lane[0];
      SIZE_WORD:    bad = (lane != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/datamemory_bytelane_load_align.sv
// Load alignment: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it to a full register value.
module mem_load_align
  import datamemory_bytelane_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] value
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  always_comb begin
    selByte = word[{lane, 3'b000} +: 8];
    selHalf = lane[1] ? word[31:16] : word[15:0];
    value   = '0;
    case (size)
      SIZE_BYTE: value = {{24{signExt & selByte[7]}}, selByte};
      SIZE_HALF: value = {{16{signExt & selHalf[15]}}, selHalf};
      SIZE_WORD: value = word;
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/datamemory_bytelane.sv
// Byte-addressed data memory for the MEM stage: little-endian byte/half/word access,
// registered loads, misalignment flagging and an optional clear sweep after reset.
module datamemory_bytelane
  import datamemory_bytelane_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRE,
  input  logic        memWE,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        dataValid,
  output logic        misaligned,
  output logic        ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [0:DEPTH_WORDS-1];

  memState_t     state;
  logic [AW-1:0] counter;

  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic          badAccess;
  logic          accept;
  logic          doWrite;
  logic          doRead;
  logic [3:0]    byteEn;
  logic [31:0]   wrLanes;
  logic [31:0]   storedWord;
  logic [31:0]   mergedWord;
  logic [31:0]   readWord;
  logic [31:0]   loadValue;

  logic          memWrEn;
  logic [AW-1:0] memWrIdx;
  logic [31:0]   memWrData;

  // Address bits above the memory size are deliberately ignored so addresses wrap.
  logic          unusedAddrBits;
  assign unusedAddrBits = ^Addr[31:AW+2];

  assign wordIdx    = Addr[AW+1:2];
  assign lane       = Addr[1:0];
  assign badAccess  = isMisaligned(size, lane);
  assign accept     = ready & ~reset & (memRE | memWE);
  assign doWrite    = accept & memWE & ~badAccess;
  assign doRead     = accept & memRE & ~badAccess;
  assign storedWord = mem[wordIdx];

  // Byte enables and store data replicated onto every lane, so the enables alone pick the target bytes.
  always_comb begin
    byteEn  = 4'b0000;
    wrLanes = DataIn;
    case (size)
      SIZE_BYTE: begin
        byteEn  = 4'b0001 << lane;
        wrLanes = {4{DataIn[7:0]}};
      end
      SIZE_HALF: begin
        byteEn  = lane[1] ? 4'b1100 : 4'b0011;
        wrLanes = {2{DataIn[15:0]}};
      end
      SIZE_WORD: begin
        byteEn  = 4'b1111;
        wrLanes = DataIn;
      end
      default: begin
        byteEn  = 4'b0000;
        wrLanes = DataIn;
      end
    endcase
  end

  always_comb begin
    mergedWord = storedWord;
    for (int k = 0; k < 4; k++) begin
      if (byteEn[k]) mergedWord[8*k +: 8] = wrLanes[8*k +: 8];
    end
  end

  // Write-first: a simultaneous read sees the word as it will be after this edge.
  assign readWord = doWrite ? mergedWord : storedWord;

  mem_load_align uLoadAlign (
    .word    (readWord),
    .lane    (lane),
    .size    (size),
    .signExt (signExt),
    .value   (loadValue)
  );

  always_comb begin
    memWrEn   = 1'b0;
    memWrIdx  = wordIdx;
    memWrData = mergedWord;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        memWrEn   = 1'b1;
        memWrIdx  = counter;
        memWrData = '0;
      end else if (doWrite) begin
        memWrEn   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWrEn) mem[memWrIdx] <= memWrData;
  end

  // Control FSM: the sweep walks every word once, then accesses are served with registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      counter    <= '0;
      DataOut    <= '0;
      dataValid  <= 1'b0;
      misaligned <= 1'b0;
      ready      <= 1'b0;
    end else begin
      dataValid  <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        ST_CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == AW'(DEPTH_WORDS - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
          if (accept) misaligned <= badAccess;
          if (doRead) begin
            dataValid <= 1'b1;
            DataOut   <= loadValue;
          end
        end
        default: begin
          state <= ST_RUN;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datamemory_bytelane.sv
// Directed bench for datamemory_bytelane (16 words, clear sweep enabled):
// sweep timing, lane placement, extension, misalignment, write-first and reset abort.
module tb_datamemory_bytelane;
  import datamemory_bytelane_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRE;
  logic        memWE;
  logic [1:0]  size;
  logic        signExt;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        dataValid;
  logic        misaligned;
  logic        ready;

  int checks = 0;
  int errors = 0;

  datamemory_bytelane #(
    .DEPTH_WORDS    (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memRE      (memRE),
    .memWE      (memWE),
    .size       (size),
    .signExt    (signExt),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .dataValid  (dataValid),
    .misaligned (misaligned),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // One access cycle; on return (a negedge) the outputs reflect that access.
  task automatic applyStimulus(input logic re, input logic we, input logic [1:0] sz,
                               input logic sx, input logic [31:0] addr, input logic [31:0] din);
    memRE   = re;
    memWE   = we;
    size    = sz;
    signExt = sx;
    Addr    = addr;
    DataIn  = din;
    step();
    memRE   = 1'b0;
    memWE   = 1'b0;
  endtask

  task automatic checkLoad(input string tag, input logic [1:0] sz, input logic sx,
                           input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, sz, sx, addr, 32'h0);
    checkOutput({tag, ".data"}, DataOut, expected);
    checkOutput({tag, ".valid"}, {31'b0, dataValid}, 32'h1);
  endtask

  // Counts cycles with ready low from reset release, optionally firing ignored requests each cycle.
  task automatic waitSweep(input string tag, input bit poke);
    int n;
    bit pulseSeen;
    n = 0;
    pulseSeen = 1'b0;
    while (!ready && n < 100) begin
      if (dataValid || misaligned) pulseSeen = 1'b1;
      if (poke) begin
        memRE   = 1'b1;
        memWE   = 1'b1;
        size    = n[0] ? SIZE_ILLEGAL : SIZE_WORD;
        Addr    = 32'h0;
        DataIn  = 32'hDEADBEEF;
      end
      n++;
      step();
    end
    if (dataValid || misaligned) pulseSeen = 1'b1;
    memRE = 1'b0;
    memWE = 1'b0;
    checkOutput({tag, ".readyLowCycles"}, n, 32'd16);
    if (poke) checkOutput({tag, ".noPulses"}, {31'b0, pulseSeen}, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    memRE   = 1'b0;
    memWE   = 1'b0;
    size    = SIZE_WORD;
    signExt = 1'b0;
    Addr    = '0;
    DataIn  = '0;
    @(negedge clk);
    step();
    step();

    checkOutput("reset.ready", {31'b0, ready}, 32'h0);
    checkOutput("reset.dataValid", {31'b0, dataValid}, 32'h0);
    checkOutput("reset.misaligned", {31'b0, misaligned}, 32'h0);
    checkOutput("reset.DataOut", DataOut, 32'h0);

    // Clear sweep timing and a read of the last word
    reset = 1'b0;
    waitSweep("sweep1", 1'b0);
    checkLoad("lw3C", SIZE_WORD, 1'b0, 32'h3C, 32'h00000000);
    step();
    checkOutput("validPulseEnds", {31'b0, dataValid}, 32'h0);

    // Lane placement and byte extension
    applyStimulus(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h8, 32'h11223344);
    applyStimulus(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'hA, 32'h000000AA);
    checkLoad("lw8", SIZE_WORD, 1'b0, 32'h8, 32'h11AA3344);
    checkLoad("lbA", SIZE_BYTE, 1'b1, 32'hA, 32'hFFFFFFAA);
    checkLoad("lbuA", SIZE_BYTE, 1'b0, 32'hA, 32'h000000AA);

    // Halves
    applyStimulus(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h6, 32'h00008001);
    checkLoad("lh6", SIZE_HALF, 1'b1, 32'h6, 32'hFFFF8001);
    checkLoad("lhu6", SIZE_HALF, 1'b0, 32'h6, 32'h00008001);
    checkLoad("lw4", SIZE_WORD, 1'b0, 32'h4, 32'h80010000);

    // Misaligned and illegal accesses
    applyStimulus(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h5, 32'h0);
    checkOutput("lw5.misaligned", {31'b0, misaligned}, 32'h1);
    checkOutput("lw5.valid", {31'b0, dataValid}, 32'h0);
    checkOutput("lw5.dataHeld", DataOut, 32'h80010000);
    applyStimulus(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h3, 32'h0000BEEF);
    checkOutput("sh3.misaligned", {31'b0, misaligned}, 32'h1);
    checkLoad("lw0AfterBadSh", SIZE_WORD, 1'b0, 32'h0, 32'h00000000);
    checkOutput("lw0.misaligned", {31'b0, misaligned}, 32'h0);
    applyStimulus(1'b1, 1'b0, SIZE_ILLEGAL, 1'b0, 32'h0, 32'h0);
    checkOutput("size11.misaligned", {31'b0, misaligned}, 32'h1);
    checkOutput("size11.valid", {31'b0, dataValid}, 32'h0);

    // Write-first and back-to-back
    applyStimulus(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hCAFEF00D);
    checkOutput("rw10.data", DataOut, 32'hCAFEF00D);
    checkOutput("rw10.valid", {31'b0, dataValid}, 32'h1);
    applyStimulus(1'b1, 1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h00000077);
    checkOutput("rwb11.data", DataOut, 32'h00000077);
    checkLoad("lw10Merged", SIZE_WORD, 1'b0, 32'h10, 32'hCAFE770D);
    applyStimulus(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h14, 32'h00000001);
    checkLoad("lw14BackToBack", SIZE_WORD, 1'b0, 32'h14, 32'h00000001);

    // Reset aborts an access in flight
    applyStimulus(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h3C, 32'h12345678);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h3C, 32'h0);
    checkOutput("resetCancelsValid", {31'b0, dataValid}, 32'h0);
    checkOutput("resetClearsDataOut", DataOut, 32'h0);

    // Reset at sweep cycle 5 restarts a full sweep; requests meanwhile are ignored
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checkOutput("midSweep.ready", {31'b0, ready}, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    waitSweep("sweep2", 1'b1);
    checkLoad("lw3CCleared", SIZE_WORD, 1'b0, 32'h3C, 32'h00000000);
    checkLoad("lw0NoGhostWrite", SIZE_WORD, 1'b0, 32'h0, 32'h00000000);

    // Upper address bits wrap onto word 0
    applyStimulus(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h5A5A5A5A);
    checkLoad("lw0Wrap", SIZE_WORD, 1'b0, 32'h0, 32'h5A5A5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
